dma_reg_if: RTL and testbench

CPU-side register access port of the 8237A-style DMA controller. It decodes chip-select, IOR/IOW strobes and A3..A0, and owns the byte-pointer flip-flop. It holds the channel address/count, mode, command, request, mask, temp and status registers, and executes the software commands (master clear, clear flip-flop, mask operations). The transfer engine reads these registers through output ports and updates them through a dedicated update port.

---
 rtl/dma_reg_if_pkg.sv | 52 +++++
 rtl/dma_strobe_edge.sv | 35 +++
 rtl/dma_reg_if.sv | 184 ++++++++++++++++++
 tb/tb_dma_reg_if.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_reg_if_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dmaRegPkg                                                 |
// | Purpose  : Shared register map, array types and byte helpers for the |
// |            DMA controller CPU register port.                         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package dmaRegPkg;

  localparam int CH_N   = 4;
  localparam int WORD_W = 16;

  // CPU register map (A3..A0)
  localparam logic [3:0] ADDR_CH0A       = 4'h0;
  localparam logic [3:0] ADDR_CH0C       = 4'h1;
  localparam logic [3:0] ADDR_CH1A       = 4'h2;
  localparam logic [3:0] ADDR_CH1C       = 4'h3;
  localparam logic [3:0] ADDR_CH2A       = 4'h4;
  localparam logic [3:0] ADDR_CH2C       = 4'h5;
  localparam logic [3:0] ADDR_CH3A       = 4'h6;
  localparam logic [3:0] ADDR_CH3C       = 4'h7;
  localparam logic [3:0] ADDR_CMD        = 4'h8;  // write command / read status
  localparam logic [3:0] ADDR_REQ        = 4'h9;
  localparam logic [3:0] ADDR_SGLMASK    = 4'hA;
  localparam logic [3:0] ADDR_MODE       = 4'hB;
  localparam logic [3:0] ADDR_CLRFF      = 4'hC;
  localparam logic [3:0] ADDR_MCLR       = 4'hD;  // write master clear / read temp
  localparam logic [3:0] ADDR_CLRMASK    = 4'hE;
  localparam logic [3:0] ADDR_WRALLMASK  = 4'hF;

  // Status byte layout
  localparam int STAT_TC_LSB  = 0;
  localparam int STAT_REQ_LSB = 4;

  typedef logic [CH_N-1:0][WORD_W-1:0] chanArr16_t;
  typedef logic [CH_N-1:0][7:0]        modeArr_t;

  // Replace the low or high byte of a 16-bit register
  function automatic logic [WORD_W-1:0] put_byte(input logic [WORD_W-1:0] w,
                                                 input logic [7:0] b,
                                                 input logic hi);
    return hi ? {b, w[7:0]} : {w[15:8], b};
  endfunction

  // Pick the low or high byte of a 16-bit register
  function automatic logic [7:0] get_byte(input logic [WORD_W-1:0] w,
                                          input logic hi);
    return hi ? w[15:8] : w[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/dma_strobe_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dma_strobe_edge                                           |
// | Purpose  : Registers an active-low strobe and flags its falling edge |
// |            one cycle later.                                          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module dma_strobe_edge (
  input  logic clk,
  input  logic resetN,
  input  logic strobeN,
  output logic fall,
  output logic active
);

  logic strbQ;
  logic strbQQ;

  // Two-stage history; reset treats the strobe as already asserted so a
  // strobe held through reset must deassert before it can produce an edge.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      strbQ  <= 1'b0;
      strbQQ <= 1'b0;
    end else begin
      strbQ  <= strobeN;
      strbQQ <= strbQ;
    end
  end

  assign fall   = strbQQ & ~strbQ;
  assign active = ~strbQ;

endmodule
`default_nettype wire

// File: rtl/dma_reg_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dma_reg_if                                                |
// | Purpose  : CPU register port of the 8237A-style DMA controller:      |
// |            decode, byte-pointer flip-flop, channel/mode/command/     |
// |            mask/request/status/temp registers, engine update port.   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module dma_reg_if
  import dmaRegPkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int REG_W  = 16
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              csN,
  input  logic              iorN,
  input  logic              iowN,
  input  logic [3:0]        addr,
  input  logic [7:0]        dbIn,
  output logic [7:0]        dbOut,
  output logic              dbOe,
  input  logic              cpuAccessEn,
  input  logic              updEn,
  input  logic [1:0]        updChan,
  input  logic [REG_W-1:0]  updAddr,
  input  logic [REG_W-1:0]  updWord,
  input  logic              reload,
  input  logic [NUM_CH-1:0] tcSet,
  input  logic [NUM_CH-1:0] maskSet,
  input  logic [NUM_CH-1:0] reqClr,
  input  logic [NUM_CH-1:0] dreqIn,
  input  logic              tempLoad,
  input  logic [7:0]        tempIn,
  output chanArr16_t        currAddr,
  output chanArr16_t        currWord,
  output modeArr_t          mode,
  output logic [7:0]        command,
  output logic [NUM_CH-1:0] request,
  output logic [NUM_CH-1:0] mask
);

  chanArr16_t        baseAddr;
  chanArr16_t        baseWord;
  logic [NUM_CH-1:0] tcBits;
  logic [7:0]        temp;
  logic              flipFlop;

  logic iorFall, iorActive, iowFall, iowActive;
  logic rdEv, wrEv;
  logic isChan;
  logic [1:0] chIdx;
  logic isWordReg;
  logic [7:0] statusByte;
  logic [7:0] rdData;

  dma_strobe_edge u_ior_edge (
    .clk     (clk),
    .resetN  (resetN),
    .strobeN (iorN),
    .fall    (iorFall),
    .active  (iorActive)
  );

  dma_strobe_edge u_iow_edge (
    .clk     (clk),
    .resetN  (resetN),
    .strobeN (iowN),
    .fall    (iowFall),
    .active  (iowActive)
  );

  // One event per strobe; a simultaneous read and write strobe is ignored
  assign rdEv = ~csN & cpuAccessEn & iorFall & ~iowActive;
  assign wrEv = ~csN & cpuAccessEn & iowFall & ~iorActive;

  assign chIdx     = addr[2:1];
  assign isWordReg = addr[0];

  // Identify the eight channel address/count locations
  always_comb begin
    isChan = 1'b0;
    case (addr)
      ADDR_CH0A, ADDR_CH0C, ADDR_CH1A, ADDR_CH1C,
      ADDR_CH2A, ADDR_CH2C, ADDR_CH3A, ADDR_CH3C: isChan = 1'b1;
      default: isChan = 1'b0;
    endcase
  end

  // Read-data mux; unmapped read addresses return zero
  always_comb begin
    statusByte = 8'h00;
    statusByte[STAT_REQ_LSB +: CH_N] = dreqIn;
    statusByte[STAT_TC_LSB  +: CH_N] = tcBits;
    rdData = 8'h00;
    if (isChan) begin
      rdData = isWordReg ? get_byte(currWord[chIdx], flipFlop)
                         : get_byte(currAddr[chIdx], flipFlop);
    end else if (addr == ADDR_CMD) begin
      rdData = statusByte;
    end else if (addr == ADDR_MCLR) begin
      rdData = temp;
    end
  end

  // Read-enable follows the live chip select and read strobe one clock later
  always_ff @(posedge clk) begin
    if (!resetN) dbOe <= 1'b0;
    else         dbOe <= ~csN & ~iorN;
  end

  // Register file: engine updates first, CPU accesses after so they win
  always_ff @(posedge clk) begin
    if (!resetN) begin
      baseAddr <= '0;
      baseWord <= '0;
      currAddr <= '0;
      currWord <= '0;
      mode     <= '0;
      command  <= '0;
      request  <= '0;
      mask     <= '1;
      tcBits   <= '0;
      temp     <= '0;
      flipFlop <= 1'b0;
      dbOut    <= '0;
    end else begin
      if (updEn) begin
        if (reload) begin
          currAddr[updChan] <= baseAddr[updChan];
          currWord[updChan] <= baseWord[updChan];
        end else begin
          currAddr[updChan] <= updAddr;
          currWord[updChan] <= updWord;
        end
      end
      tcBits  <= tcBits | tcSet;
      mask    <= mask | maskSet;
      request <= request & ~reqClr;
      if (tempLoad) temp <= tempIn;

      if (rdEv) begin
        dbOut <= rdData;
        if (isChan) flipFlop <= ~flipFlop;
        // Status read clears TC bits, but a same-cycle set still lands
        if (addr == ADDR_CMD) tcBits <= tcSet;
      end

      if (wrEv) begin
        case (addr)
          ADDR_CH0A, ADDR_CH1A, ADDR_CH2A, ADDR_CH3A: begin
            baseAddr[chIdx] <= put_byte(baseAddr[chIdx], dbIn, flipFlop);
            currAddr[chIdx] <= put_byte(currAddr[chIdx], dbIn, flipFlop);
            flipFlop        <= ~flipFlop;
          end
          ADDR_CH0C, ADDR_CH1C, ADDR_CH2C, ADDR_CH3C: begin
            baseWord[chIdx] <= put_byte(baseWord[chIdx], dbIn, flipFlop);
            currWord[chIdx] <= put_byte(currWord[chIdx], dbIn, flipFlop);
            flipFlop        <= ~flipFlop;
          end
          ADDR_CMD:       command <= dbIn;
          ADDR_REQ:       request[dbIn[1:0]] <= dbIn[2];
          ADDR_SGLMASK:   mask[dbIn[1:0]] <= dbIn[2];
          ADDR_MODE:      mode[dbIn[1:0]] <= dbIn;
          ADDR_CLRFF:     flipFlop <= 1'b0;
          ADDR_MCLR: begin
            command  <= '0;
            tcBits   <= '0;
            request  <= '0;
            temp     <= '0;
            flipFlop <= 1'b0;
            mask     <= '1;
          end
          ADDR_CLRMASK:   mask <= '0;
          ADDR_WRALLMASK: mask <= dbIn[NUM_CH-1:0];
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_reg_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_dma_reg_if                                             |
// | Purpose  : Self-checking bench for dma_reg_if with a register-level  |
// |            reference model and randomized traffic.                   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_dma_reg_if;
  import dmaRegPkg::*;

  logic clk = 1'b0;
  logic resetN, csN, iorN, iowN, cpuAccessEn;
  logic [3:0] addr;
  logic [7:0] dbIn, dbOut;
  logic dbOe;
  logic updEn, reload, tempLoad;
  logic [1:0] updChan;
  logic [15:0] updAddr, updWord;
  logic [3:0] tcSet, maskSet, reqClr, dreqIn;
  logic [7:0] tempIn;
  chanArr16_t currAddr, currWord;
  modeArr_t mode;
  logic [7:0] command;
  logic [3:0] request, mask;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [15:0] m_ba[4], m_bw[4], m_ca[4], m_cw[4];
  logic [7:0]  m_mode[4];
  logic [7:0]  m_cmd, m_temp;
  logic [3:0]  m_req, m_mask, m_tc;
  bit          m_ff;

  dma_reg_if #(.NUM_CH(4), .REG_W(16)) dut (
    .clk(clk), .resetN(resetN), .csN(csN), .iorN(iorN), .iowN(iowN),
    .addr(addr), .dbIn(dbIn), .dbOut(dbOut), .dbOe(dbOe),
    .cpuAccessEn(cpuAccessEn), .updEn(updEn), .updChan(updChan),
    .updAddr(updAddr), .updWord(updWord), .reload(reload),
    .tcSet(tcSet), .maskSet(maskSet), .reqClr(reqClr), .dreqIn(dreqIn),
    .tempLoad(tempLoad), .tempIn(tempIn), .currAddr(currAddr),
    .currWord(currWord), .mode(mode), .command(command),
    .request(request), .mask(mask)
  );

  always #5 clk = ~clk;

  function automatic void m_reset();
    for (int c = 0; c < 4; c++) begin
      m_ba[c] = 0; m_bw[c] = 0; m_ca[c] = 0; m_cw[c] = 0; m_mode[c] = 0;
    end
    m_cmd = 0; m_temp = 0; m_req = 0; m_mask = 4'hF; m_tc = 0; m_ff = 0;
  endfunction

  function automatic logic [15:0] m_set_byte(input logic [15:0] w, input logic [7:0] d, input bit hi);
    if (hi) return (w & 16'h00FF) | (16'(d) << 8);
    return (w & 16'hFF00) | 16'(d);
  endfunction

  function automatic void m_write(input logic [3:0] a, input logic [7:0] d);
    int ch;
    ch = int'(a[2:1]);
    if (a < 4'd8) begin
      if (a[0] == 1'b0) begin
        m_ba[ch] = m_set_byte(m_ba[ch], d, m_ff);
        m_ca[ch] = m_set_byte(m_ca[ch], d, m_ff);
      end else begin
        m_bw[ch] = m_set_byte(m_bw[ch], d, m_ff);
        m_cw[ch] = m_set_byte(m_cw[ch], d, m_ff);
      end
      m_ff = !m_ff;
    end else begin
      case (a)
        4'h8: m_cmd = d;
        4'h9: m_req[d[1:0]] = d[2];
        4'hA: m_mask[d[1:0]] = d[2];
        4'hB: m_mode[d[1:0]] = d;
        4'hC: m_ff = 0;
        4'hD: begin m_cmd = 0; m_tc = 0; m_req = 0; m_temp = 0; m_ff = 0; m_mask = 4'hF; end
        4'hE: m_mask = 0;
        default: m_mask = d[3:0];
      endcase
    end
  endfunction

  function automatic logic [7:0] m_read(input logic [3:0] a, input logic [3:0] dreq);
    logic [15:0] r;
    logic [7:0] v;
    v = 8'h00;
    if (a < 4'd8) begin
      r = a[0] ? m_cw[a[2:1]] : m_ca[a[2:1]];
      v = m_ff ? r[15:8] : r[7:0];
      m_ff = !m_ff;
    end else if (a == 4'h8) begin
      v = {dreq, m_tc};
      m_tc = 0;
    end else if (a == 4'hD) begin
      v = m_temp;
    end
    return v;
  endfunction

  function automatic void m_engine(input bit ue, input logic [1:0] ch, input logic [15:0] ua,
                                   input logic [15:0] uw, input bit rl, input logic [3:0] tc,
                                   input logic [3:0] ms, input logic [3:0] rc, input bit tl,
                                   input logic [7:0] ti);
    if (ue) begin
      if (rl) begin m_ca[ch] = m_ba[ch]; m_cw[ch] = m_bw[ch]; end
      else    begin m_ca[ch] = ua;       m_cw[ch] = uw;       end
    end
    m_tc   = m_tc | tc;
    m_mask = m_mask | ms;
    m_req  = m_req & ~rc;
    if (tl) m_temp = ti;
  endfunction

  // One CPU bus cycle; optional engine activity placed in the event cycle
  task automatic cpu_op(input bit wr, input logic [3:0] a, input logic [7:0] d,
                        input logic [3:0] tc, input logic [3:0] ms, input bit ue,
                        input logic [1:0] uch, input logic [15:0] ua, input logic [15:0] uw,
                        output logic [7:0] rd, output logic oe);
    csN = 0; addr = a; dbIn = d;
    if (wr) iowN = 0; else iorN = 0;
    @(posedge clk); #1;
    tcSet = tc; maskSet = ms; updEn = ue; updChan = uch; updAddr = ua; updWord = uw;
    @(posedge clk); #1;
    tcSet = 0; maskSet = 0; updEn = 0;
    @(posedge clk); #1;
    rd = dbOut; oe = dbOe;
    iowN = 1; iorN = 1;
    @(posedge clk); #1;
    csN = 1;
    @(posedge clk); #1;
  endtask

  task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
    logic [7:0] rd;
    logic oe;
    cpu_op(1'b1, a, d, 4'h0, 4'h0, 1'b0, 2'd0, 16'h0, 16'h0, rd, oe);
    m_write(a, d);
  endtask

  task automatic cpu_rd(input logic [3:0] a, output logic [7:0] rd, output logic [7:0] ex, output logic oe);
    ex = m_read(a, dreqIn);
    cpu_op(1'b0, a, 8'h00, 4'h0, 4'h0, 1'b0, 2'd0, 16'h0, 16'h0, rd, oe);
  endtask

  task automatic eng(input bit ue, input logic [1:0] ch, input logic [15:0] ua, input logic [15:0] uw,
                     input bit rl, input logic [3:0] tc, input logic [3:0] ms, input logic [3:0] rc,
                     input bit tl, input logic [7:0] ti);
    updEn = ue; updChan = ch; updAddr = ua; updWord = uw; reload = rl;
    tcSet = tc; maskSet = ms; reqClr = rc; tempLoad = tl; tempIn = ti;
    @(posedge clk); #1;
    updEn = 0; reload = 0; tcSet = 0; maskSet = 0; reqClr = 0; tempLoad = 0;
    m_engine(ue, ch, ua, uw, rl, tc, ms, rc, tl, ti);
  endtask

  task automatic test_reset();
    logic [7:0] rd, ex;
    logic oe;
    resetN = 0;
    repeat (3) @(posedge clk);
    #1 resetN = 1;
    m_reset();
    n_cmp++; if (mask !== 4'hF) begin n_err++; $display("FAIL reset_mask: got %h expected f", mask); end
    n_cmp++; if (currAddr !== '0) begin n_err++; $display("FAIL reset_curraddr: got %h expected 0", currAddr); end
    n_cmp++; if (dbOut !== 8'h00 || dbOe !== 1'b0) begin n_err++; $display("FAIL reset_db: got %h/%b expected 00/0", dbOut, dbOe); end
    n_cmp++; if (command !== 8'h00 || request !== 4'h0) begin n_err++; $display("FAIL reset_cmd_req: got %h/%h expected 00/0", command, request); end
    dreqIn = 0;
    cpu_rd(4'h8, rd, ex, oe);
    n_cmp++; if (rd !== 8'h00) begin n_err++; $display("FAIL reset_status: got %h expected 00", rd); end
  endtask

  task automatic test_program();
    logic [7:0] rd, ex;
    logic oe;
    cpu_wr(4'hC, 8'h00);
    cpu_wr(4'h2, 8'h34);
    cpu_wr(4'h2, 8'h12);
    n_cmp++; if (currAddr[1] !== 16'h1234) begin n_err++; $display("FAIL prog_ch1_addr: got %h expected 1234", currAddr[1]); end
    cpu_rd(4'h2, rd, ex, oe);
    n_cmp++; if (rd !== 8'h34 || ex !== 8'h34) begin n_err++; $display("FAIL prog_read_lo: got %h expected 34", rd); end
    n_cmp++; if (oe !== 1'b1) begin n_err++; $display("FAIL prog_dboe: got %b expected 1", oe); end
    cpu_rd(4'h2, rd, ex, oe);
    n_cmp++; if (rd !== 8'h12) begin n_err++; $display("FAIL prog_read_hi: got %h expected 12", rd); end
    n_cmp++; if (dbOe !== 1'b0) begin n_err++; $display("FAIL prog_dboe_idle: got %b expected 0", dbOe); end
    eng(1'b1, 2'd1, 16'h0000, 16'h0000, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 8'h00);
    n_cmp++; if (currAddr[1] !== 16'h0000) begin n_err++; $display("FAIL prog_engine_upd: got %h expected 0000", currAddr[1]); end
    eng(1'b1, 2'd1, 16'h0000, 16'h0000, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 8'h00);
    n_cmp++; if (currAddr[1] !== 16'h1234) begin n_err++; $display("FAIL prog_base: got %h expected 1234", currAddr[1]); end
  endtask

  task automatic test_status();
    logic [7:0] rd, ex;
    logic oe;
    eng(1'b0, 2'd0, 16'h0, 16'h0, 1'b0, 4'b0101, 4'h0, 4'h0, 1'b0, 8'h00);
    dreqIn = 4'b0010;
    cpu_rd(4'h8, rd, ex, oe);
    n_cmp++; if (rd !== 8'h25) begin n_err++; $display("FAIL status_first: got %h expected 25", rd); end
    cpu_rd(4'h8, rd, ex, oe);
    n_cmp++; if (rd !== 8'h20) begin n_err++; $display("FAIL status_cleared: got %h expected 20", rd); end
    ex = m_read(4'h8, dreqIn);
    m_tc = m_tc | 4'b0001;
    cpu_op(1'b0, 4'h8, 8'h00, 4'b0001, 4'h0, 1'b0, 2'd0, 16'h0, 16'h0, rd, oe);
    n_cmp++; if (rd !== 8'h20) begin n_err++; $display("FAIL status_collide_old: got %h expected 20", rd); end
    cpu_rd(4'h8, rd, ex, oe);
    n_cmp++; if (rd !== 8'h21) begin n_err++; $display("FAIL status_collide_set: got %h expected 21", rd); end
    dreqIn = 0;
  endtask

  task automatic test_mask();
    cpu_wr(4'hE, 8'h00);
    n_cmp++; if (mask !== 4'h0) begin n_err++; $display("FAIL mask_clear_all: got %h expected 0", mask); end
    cpu_wr(4'hA, 8'h06);
    n_cmp++; if (mask !== 4'b0100) begin n_err++; $display("FAIL mask_single: got %b expected 0100", mask); end
    cpu_wr(4'hF, 8'h0B);
    n_cmp++; if (mask !== 4'hB) begin n_err++; $display("FAIL mask_write_all: got %h expected b", mask); end
  endtask

  task automatic test_reload();
    cpu_wr(4'hC, 8'h00);
    cpu_wr(4'h0, 8'hCD);
    cpu_wr(4'h0, 8'hAB);
    n_cmp++; if (currAddr[0] !== 16'hABCD) begin n_err++; $display("FAIL reload_prog: got %h expected abcd", currAddr[0]); end
    eng(1'b1, 2'd0, 16'hABCE, 16'h0042, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 8'h00);
    n_cmp++; if (currAddr[0] !== 16'hABCE) begin n_err++; $display("FAIL reload_upd: got %h expected abce", currAddr[0]); end
    eng(1'b1, 2'd0, 16'h5555, 16'h5555, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 8'h00);
    n_cmp++; if (currAddr[0] !== 16'hABCD) begin n_err++; $display("FAIL reload_addr: got %h expected abcd", currAddr[0]); end
    n_cmp++; if (currWord[0] !== m_bw[0]) begin n_err++; $display("FAIL reload_word: got %h expected %h", currWord[0], m_bw[0]); end
  endtask

  task automatic test_collisions();
    logic [7:0] rd, ex;
    logic oe;
    logic [15:0] keep;
    cpu_wr(4'hC, 8'h00);
    keep = m_ca[1];
    cpu_op(1'b1, 4'h2, 8'h99, 4'h0, 4'h0, 1'b1, 2'd1, 16'hFFFF, 16'h7777, rd, oe);
    m_engine(1'b1, 2'd1, 16'hFFFF, 16'h7777, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 8'h00);
    m_ca[1] = keep;
    m_write(4'h2, 8'h99);
    n_cmp++; if (currAddr[1] !== 16'h1299) begin n_err++; $display("FAIL cpu_wins_addr: got %h expected 1299", currAddr[1]); end
    n_cmp++; if (currWord[1] !== 16'h7777) begin n_err++; $display("FAIL engine_other_reg: got %h expected 7777", currWord[1]); end
    // Master clear with same-cycle TC and mask sets
    cpu_wr(4'h8, 8'h3C);
    cpu_wr(4'h9, 8'h05);
    cpu_wr(4'hE, 8'h00);
    cpu_wr(4'hC, 8'h00);
    cpu_wr(4'h1, 8'h55);
    keep = m_ca[0];
    cpu_op(1'b1, 4'hD, 8'h00, 4'b0010, 4'b0001, 1'b0, 2'd0, 16'h0, 16'h0, rd, oe);
    m_engine(1'b0, 2'd0, 16'h0, 16'h0, 1'b0, 4'b0010, 4'b0001, 4'h0, 1'b0, 8'h00);
    m_write(4'hD, 8'h00);
    n_cmp++; if (mask !== 4'hF) begin n_err++; $display("FAIL mclr_mask: got %h expected f", mask); end
    n_cmp++; if (command !== 8'h00 || request !== 4'h0) begin n_err++; $display("FAIL mclr_cmd_req: got %h/%h expected 00/0", command, request); end
    n_cmp++; if (currAddr[0] !== keep) begin n_err++; $display("FAIL mclr_addr_kept: got %h expected %h", currAddr[0], keep); end
    dreqIn = 0;
    cpu_rd(4'h8, rd, ex, oe);
    n_cmp++; if (rd !== 8'h00) begin n_err++; $display("FAIL mclr_status: got %h expected 00", rd); end
    cpu_wr(4'h1, 8'h77);
    n_cmp++; if (currWord[0] !== m_cw[0] || currWord[0][7:0] !== 8'h77) begin n_err++; $display("FAIL mclr_ff: got %h expected %h", currWord[0], m_cw[0]); end
  endtask

  task automatic test_strobe_rules();
    logic [7:0] rd;
    logic oe;
    csN = 0; addr = 4'h8; dbIn = 8'hA5; iowN = 0; iorN = 0;
    repeat (3) @(posedge clk);
    #1 iowN = 1; iorN = 1;
    repeat (2) @(posedge clk);
    #1 csN = 1;
    @(posedge clk); #1;
    n_cmp++; if (command !== m_cmd) begin n_err++; $display("FAIL both_strobes: got %h expected %h", command, m_cmd); end
    cpuAccessEn = 0;
    cpu_op(1'b1, 4'h8, 8'h5A, 4'h0, 4'h0, 1'b0, 2'd0, 16'h0, 16'h0, rd, oe);
    cpuAccessEn = 1;
    n_cmp++; if (command !== m_cmd) begin n_err++; $display("FAIL access_disabled: got %h expected %h", command, m_cmd); end
    csN = 0; addr = 4'h8; dbIn = 8'h3C; iowN = 0;
    @(posedge clk);
    #1 resetN = 0;
    repeat (2) @(posedge clk);
    #1 resetN = 1;
    m_reset();
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (command !== 8'h00 || mask !== 4'hF) begin n_err++; $display("FAIL reset_mid_strobe: got %h/%h expected 00/f", command, mask); end
    iowN = 1;
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (command !== 8'h00) begin n_err++; $display("FAIL strobe_release: got %h expected 00", command); end
    iowN = 0;
    repeat (3) @(posedge clk); #1;
    m_write(4'h8, 8'h3C);
    n_cmp++; if (command !== 8'h3C) begin n_err++; $display("FAIL strobe_reassert: got %h expected 3c", command); end
    iowN = 1;
    @(posedge clk); #1 csN = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [7:0] rd, ex;
    logic oe;
    logic [3:0] a;
    for (int it = 0; it < 200; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          a = 4'($urandom_range(0, 15));
          cpu_wr(a, 8'($urandom));
        end
        1: begin
          a = 4'($urandom_range(0, 15));
          dreqIn = 4'($urandom);
          cpu_rd(a, rd, ex, oe);
          n_cmp++; if (rd !== ex || oe !== 1'b1) begin n_err++; $display("FAIL rand_read a=%h: got %h/%b expected %h/1", a, rd, oe, ex); end
        end
        default: begin
          eng(1'($urandom), 2'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
              4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
              4'($urandom), 1'($urandom), 8'($urandom));
        end
      endcase
      for (int c = 0; c < 4; c++) begin
        n_cmp++; if (currAddr[c] !== m_ca[c]) begin n_err++; $display("FAIL rand_curraddr%0d: got %h expected %h", c, currAddr[c], m_ca[c]); end
        n_cmp++; if (currWord[c] !== m_cw[c]) begin n_err++; $display("FAIL rand_currword%0d: got %h expected %h", c, currWord[c], m_cw[c]); end
        n_cmp++; if (mode[c] !== m_mode[c]) begin n_err++; $display("FAIL rand_mode%0d: got %h expected %h", c, mode[c], m_mode[c]); end
      end
      n_cmp++; if (command !== m_cmd) begin n_err++; $display("FAIL rand_command: got %h expected %h", command, m_cmd); end
      n_cmp++; if (request !== m_req) begin n_err++; $display("FAIL rand_request: got %h expected %h", request, m_req); end
      n_cmp++; if (mask !== m_mask) begin n_err++; $display("FAIL rand_mask: got %h expected %h", mask, m_mask); end
    end
  endtask

  initial begin
    resetN = 0; csN = 1; iorN = 1; iowN = 1; cpuAccessEn = 1;
    addr = 0; dbIn = 0; updEn = 0; updChan = 0; updAddr = 0; updWord = 0;
    reload = 0; tcSet = 0; maskSet = 0; reqClr = 0; dreqIn = 0;
    tempLoad = 0; tempIn = 0;
    m_reset();
    test_reset();
    test_program();
    test_status();
    test_mask();
    test_reload();
    test_collisions();
    test_strobe_rules();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
